// File: rtl/regfile_pkg.sv
// regfile_pkg: register file geometry shared by the regfile and its writeback arbiter
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NREGS      = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requesters, reservation port and regfile write port
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;
    logic             a_valid;
    logic             a_ready;
    reg_addr_t        a_addr;
    reg_data_t        a_data;
    logic             b_valid;
    logic             b_ready;
    reg_addr_t        b_addr;
    reg_data_t        b_data;
    logic             rsv_valid;
    reg_addr_t        rsv_addr;
    logic [NREGS-1:0] busy;
    logic             we3;
    reg_addr_t        wa3;
    reg_data_t        wd3;
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr,
        input  a_ready, b_ready, busy, we3, wa3, wd3
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr,
        output a_ready, b_ready, busy, we3, wa3, wd3
    );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-destination bitmap; a set and clear of the same register resolve to set
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set,
    input  reg_addr_t        i_set_addr,
    input  logic             i_clr,
    input  reg_addr_t        i_clr_addr,
    output logic [NREGS-1:0] o_busy
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    always_comb begin
        w_set = i_set ? (NREGS'(1) << i_set_addr) : '0;
        w_clr = i_clr ? (NREGS'(1) << i_clr_addr) : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREGS'(1);
    end
    assign o_busy = r_busy;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: A-priority arbitration with B starvation guard onto a registered regfile write port
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    logic [3:0] r_starve;
    logic       r_we3;
    reg_addr_t  r_wa3;
    reg_data_t  r_wd3;
    logic       w_force_b;
    logic       w_a_acc;
    logic       w_b_acc;
    logic       w_acc;
    reg_addr_t  w_addr;
    reg_data_t  w_data;
    always_comb begin
        w_force_b   = r_starve >= 4'(STARVE_MAX);
        bus.a_ready = !(w_force_b && bus.b_valid);
        bus.b_ready = !bus.a_valid || w_force_b;
        w_a_acc     = bus.a_valid && bus.a_ready;
        w_b_acc     = bus.b_valid && bus.b_ready;
        w_acc       = w_a_acc || w_b_acc;
        w_addr      = w_b_acc ? bus.b_addr : bus.a_addr;
        w_data      = w_b_acc ? bus.b_data : bus.a_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n)                        r_starve <= '0;
        else if (!bus.b_valid || w_b_acc)  r_starve <= '0;
        else if (r_starve != 4'hF)         r_starve <= r_starve + 4'd1;
    end
    // r0 writes are still handshaken; only the enable is suppressed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_acc && (w_addr != '0);
            if (w_acc) begin
                r_wa3 <= w_addr;
                r_wd3 <= w_data;
            end
        end
    end
    assign bus.we3 = r_we3;
    assign bus.wa3 = r_wa3;
    assign bus.wd3 = r_wd3;
    wb_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set      (bus.rsv_valid),
        .i_set_addr (bus.rsv_addr),
        .i_clr      (w_b_acc),
        .i_clr_addr (bus.b_addr),
        .o_busy     (bus.busy)
    );
endmodule
